// File: rtl/packer_arbiter.sv
// packer_arbiter
//   Moves a configured number of packed words from NUM_CH upstream packer
//   channels into a single registered output slot. Channels are served
//   round-robin. A frame runs IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//
// Ports
//   clk           sole clock, rising edge
//   Reset         synchronous active-high reset
//   Cfg_Start     frame start pulse, honoured only in IDLE
//   Cfg_NumWords  word count for the frame, latched with an accepted start
//   Packed_RdyRd  per-channel "word available" level
//   Packed_DatRd  per-channel word, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   Packed_EnRd   one-hot read strobe to the granted channel (combinational)
//   Out_Valid     output slot holds a word
//   Out_Ready     downstream accepts the word this cycle
//   Out_Dat       registered output word
//   Out_Ch        source channel of Out_Dat
//   Busy          high whenever the controller is not idle
//   Done          one-cycle pulse at frame completion
module packer_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 16,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         Cfg_Start,
  input  logic [CNT_WIDTH-1:0]         Cfg_NumWords,
  input  logic [NUM_CH-1:0]            Packed_RdyRd,
  input  logic [NUM_CH*DATA_WIDTH-1:0] Packed_DatRd,
  output logic [NUM_CH-1:0]            Packed_EnRd,
  output logic                         Out_Valid,
  input  logic                         Out_Ready,
  output logic [DATA_WIDTH-1:0]        Out_Dat,
  output logic [CH_W-1:0]              Out_Ch,
  output logic                         Busy,
  output logic                         Done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_r, state_next_s;
  logic [CNT_WIDTH-1:0]  remaining_r;
  logic [CH_W-1:0]       last_grant_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_dat_r;
  logic [CH_W-1:0]       out_ch_r;

  logic                  slot_free_s;
  logic                  grant_found_s;
  logic [CH_W-1:0]       grant_idx_s;
  logic                  grant_s;
  logic                  last_word_s;

  // Channel visited k steps after the last grant, wrapping at NUM_CH
  // (NUM_CH need not be a power of two, so plain truncation is not enough).
  function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] last, input int k);
    int sum;
    sum = (int'(last) + 1 + k) % NUM_CH;
    return sum[CH_W-1:0];
  endfunction

  assign slot_free_s = !out_valid_r || Out_Ready;
  assign last_word_s = (remaining_r == CNT_WIDTH'(1));

  // Round-robin search: first ready channel after the last grant.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {CH_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (!grant_found_s && Packed_RdyRd[rr_index(last_grant_r, k)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = rr_index(last_grant_r, k);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Reset gates the strobe so no upstream word is consumed while reset is held.
  assign grant_s = (state_r == RUN) && slot_free_s && grant_found_s &&
                   (remaining_r != {CNT_WIDTH{1'b0}}) && !Reset;

  // One-hot read strobe for the granted channel.
  always_comb begin
    Packed_EnRd = {NUM_CH{1'b0}};
    if (grant_s) begin
      Packed_EnRd[grant_idx_s] = 1'b1;
    end else begin
      Packed_EnRd = {NUM_CH{1'b0}};
    end
  end

  // Frame sequencing.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (Cfg_Start) begin
          state_next_s = (Cfg_NumWords != {CNT_WIDTH{1'b0}}) ? RUN : DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (grant_s && last_word_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        // Leave once the slot is empty or its last word hands off now.
        if (slot_free_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, counter, round-robin pointer and output slot registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r      <= IDLE;
      remaining_r  <= {CNT_WIDTH{1'b0}};
      last_grant_r <= CH_W'(NUM_CH - 1);  // next search starts at channel 0
      out_valid_r  <= 1'b0;
      out_dat_r    <= {DATA_WIDTH{1'b0}};
      out_ch_r     <= {CH_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (state_r == IDLE && Cfg_Start) begin
        remaining_r <= Cfg_NumWords;
      end else if (grant_s) begin
        remaining_r <= remaining_r - CNT_WIDTH'(1);
      end else begin
        remaining_r <= remaining_r;
      end
      if (grant_s) begin
        out_dat_r    <= Packed_DatRd[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
        out_ch_r     <= grant_idx_s;
        out_valid_r  <= 1'b1;
        last_grant_r <= grant_idx_s;
      end else if (out_valid_r && Out_Ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign Out_Valid = out_valid_r;
  assign Out_Dat   = out_dat_r;
  assign Out_Ch    = out_ch_r;
  assign Busy      = (state_r != IDLE);
  assign Done      = (state_r == DONE);

endmodule

// File: tb/tb_packer_arbiter.sv
// tb_packer_arbiter
//   Directed frames for the headline scenarios followed by a randomized
//   phase. A transaction-level reference model (word count, rotating
//   pointer, one-slot output buffer) predicts every output each cycle.
module tb_packer_arbiter;
  localparam int NUM_CH = 4;
  localparam int DW     = 128;
  localparam int CW     = 16;

  logic                   clk = 1'b0;
  logic                   Reset;
  logic                   Cfg_Start;
  logic [CW-1:0]          Cfg_NumWords;
  logic [NUM_CH-1:0]      Packed_RdyRd;
  logic [NUM_CH*DW-1:0]   Packed_DatRd;
  logic [NUM_CH-1:0]      Packed_EnRd;
  logic                   Out_Valid;
  logic                   Out_Ready;
  logic [DW-1:0]          Out_Dat;
  logic [1:0]             Out_Ch;
  logic                   Busy;
  logic                   Done;

  packer_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .Reset(Reset), .Cfg_Start(Cfg_Start), .Cfg_NumWords(Cfg_NumWords),
    .Packed_RdyRd(Packed_RdyRd), .Packed_DatRd(Packed_DatRd), .Packed_EnRd(Packed_EnRd),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Dat(Out_Dat), .Out_Ch(Out_Ch),
    .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit      m_active;   // frame accepted and not yet finished
  bit      m_done;     // completion cycle
  int      m_rem;      // words still to be granted
  int      m_ptr;      // channel where the next search begins
  bit      m_vld;
  logic [DW-1:0] m_dat;
  int      m_ch;

  bit      cap_on = 1'b0;
  int      cap_q[$];
  int      done_cnt = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_CH*DW/32; i++) Packed_DatRd[i*32 +: 32] = $urandom();
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic step();
    int g;
    int c;
    int rem_old;
    bit vld_old;
    logic [NUM_CH-1:0] exp_en;
    #3;
    g = -1;
    if (!Reset && m_active && m_rem > 0 && (!m_vld || Out_Ready)) begin
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_ptr + k) % NUM_CH;
        if (g < 0 && Packed_RdyRd[c]) g = c;
      end
    end
    exp_en = '0;
    if (g >= 0) exp_en[g] = 1'b1;
    chk("en_rd",     DW'(Packed_EnRd), DW'(exp_en));
    chk("out_valid", DW'(Out_Valid),   DW'(m_vld));
    chk("out_dat",   Out_Dat,          m_dat);
    chk("out_ch",    DW'(Out_Ch),      DW'(m_ch));
    chk("busy",      DW'(Busy),        DW'(m_active || m_done));
    chk("done",      DW'(Done),        DW'(m_done));
    if (Done) done_cnt++;
    if (cap_on && g >= 0) cap_q.push_back(g);

    if (Reset) begin
      m_active = 0; m_done = 0; m_rem = 0; m_ptr = 0;
      m_vld = 0; m_dat = '0; m_ch = 0;
    end else begin
      rem_old = m_rem;
      vld_old = m_vld;
      if (g >= 0) begin
        m_dat = Packed_DatRd[g*DW +: DW];
        m_ch  = g;
        m_vld = 1;
        m_rem = m_rem - 1;
        m_ptr = (g + 1) % NUM_CH;
      end else if (m_vld && Out_Ready) begin
        m_vld = 0;
      end
      if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (Cfg_Start) begin
          if (Cfg_NumWords != 0) begin m_active = 1; m_rem = Cfg_NumWords; end
          else m_done = 1;
        end
      end else if (rem_old == 0 && (!vld_old || Out_Ready)) begin
        m_active = 0;
        m_done   = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      rand_data();
      step();
    end
  endtask

  task automatic start(input int nw);
    Cfg_Start = 1'b1;
    Cfg_NumWords = CW'(nw);
    rand_data();
    step();
    Cfg_Start = 1'b0;
    Cfg_NumWords = CW'($urandom_range(0, 200));
  endtask

  initial begin
    int dc;
    int first;
    Reset = 1'b1; Cfg_Start = 1'b0; Cfg_NumWords = '0;
    Packed_RdyRd = '0; Packed_DatRd = '0; Out_Ready = 1'b0;
    m_active = 0; m_done = 0; m_rem = 0; m_ptr = 0; m_vld = 0; m_dat = '0; m_ch = 0;
    @(posedge clk); #1;

    // Reset held: strobe must stay low even with a ready channel
    Packed_RdyRd = 4'b1111;
    steps(3);
    Reset = 1'b0;
    Packed_RdyRd = '0;
    steps(1);
    chk("reset_busy", DW'(Busy), DW'(1'b0));
    chk("reset_valid", DW'(Out_Valid), DW'(1'b0));

    // All channels ready, 8 words, sink always ready
    Packed_RdyRd = 4'b1111; Out_Ready = 1'b1;
    cap_on = 1'b1; cap_q.delete(); dc = done_cnt;
    start(8);
    steps(12);
    cap_on = 1'b0;
    chk("rr_len", DW'(cap_q.size()), DW'(8));
    for (int i = 0; i < 8 && i < cap_q.size(); i++) chk("rr_order", DW'(cap_q[i]), DW'(i % 4));
    chk("rr_done_count", DW'(done_cnt - dc), DW'(1));

    // Only channel 2 ready, 3 words
    Packed_RdyRd = 4'b0100;
    cap_on = 1'b1; cap_q.delete();
    start(3);
    steps(6);
    cap_on = 1'b0;
    chk("ch2_len", DW'(cap_q.size()), DW'(3));
    for (int i = 0; i < cap_q.size(); i++) chk("ch2_grant", DW'(cap_q[i]), DW'(2));

    // Back-pressure: 5 stalled cycles, then release
    Packed_RdyRd = 4'b1111; Out_Ready = 1'b0;
    start(4);
    steps(6);
    Out_Ready = 1'b1;
    steps(8);

    // Zero-word frame: straight to completion, no grant
    dc = done_cnt;
    cap_on = 1'b1; cap_q.delete();
    start(0);
    steps(3);
    cap_on = 1'b0;
    chk("zero_no_grant", DW'(cap_q.size()), DW'(0));
    chk("zero_done_count", DW'(done_cnt - dc), DW'(1));

    // Reset after 3 of 10 words; frame abandoned, next frame starts at ch0
    dc = done_cnt;
    start(10);
    steps(3);
    Reset = 1'b1;
    steps(1);
    Reset = 1'b0;
    steps(2);
    chk("abort_no_done", DW'(done_cnt - dc), DW'(0));
    cap_on = 1'b1; cap_q.delete();
    start(2);
    steps(5);
    cap_on = 1'b0;
    first = (cap_q.size() > 0) ? cap_q[0] : -1;
    chk("abort_first_ch0", DW'(first), DW'(0));

    // Start pulsed mid-frame with 99 must not change the count
    cap_on = 1'b1; cap_q.delete();
    start(5);
    steps(2);
    start(99);
    steps(8);
    cap_on = 1'b0;
    chk("restart_ignored", DW'(cap_q.size()), DW'(5));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      Packed_RdyRd = NUM_CH'($urandom());
      Out_Ready    = ($urandom_range(0, 3) != 0);
      Cfg_Start    = ($urandom_range(0, 9) == 0);
      Cfg_NumWords = CW'($urandom_range(0, 12));
      Reset        = ($urandom_range(0, 199) == 0);
      rand_data();
      step();
    end
    Reset = 1'b0; Cfg_Start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
